// File: rtl/bus_pkg.sv
// Shared definitions for the DMA: register offsets, CTRL bit positions, sequencer states.
// No logic of its own; the byte-merge helper is purely combinational.
// Imported by the responder and the sequencer so both agree on the register map.
package bus_pkg;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_ERR   = 2;
    localparam int CTRL_SINC  = 3;
    localparam int CTRL_DINC  = 4;
    localparam int CTRL_IE    = 5;
    localparam int CTRL_ABORT = 6;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } dma_state_e;

    // Replace only the bytes selected by strb
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_dma_regs.sv
// Config responder: SRC/DST/LEN/CTRL register file, W1C status, start/abort pulses, irq.
// Latency: ready pulses the cycle after valid is seen; rdata is valid alongside it.
// Backpressure: none; back-to-back accesses complete every 2 cycles, ready=1 then 0.
module bus_dma_regs
    import bus_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    output logic                 ready,
    input  logic [3:0]           wstrb,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic                 busy,
    input  logic [LEN_WIDTH-1:0] cnt_live,
    input  logic                 set_done,
    input  logic                 set_err,
    output logic [31:0]          src,
    output logic [31:0]          dst,
    output logic [LEN_WIDTH-1:0] len,
    output logic                 sinc,
    output logic                 dinc,
    output logic                 go,
    output logic                 abort_req,
    output logic                 irq
);

    logic        done;
    logic        err;
    logic        ie;
    logic        acc;
    logic        wr_acc;
    logic        ctrl_wr;
    logic        start_wr;
    logic        zero_start;
    logic        clr_done;
    logic        clr_err;
    logic [1:0]  idx;
    logic [31:0] len_ext;
    logic [31:0] len_merged;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign idx         = addr[3:2];
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    // Decode the current access: one access per valid, taken while ready is low
    always_comb begin
        acc        = valid & ~ready;
        wr_acc     = acc & (wstrb != 4'h0);
        ctrl_wr    = wr_acc & (idx == REG_CTRL) & wstrb[0];
        start_wr   = ctrl_wr & wdata[CTRL_START] & ~busy;
        go         = start_wr & (len != '0);
        zero_start = start_wr & (len == '0);
        abort_req  = ctrl_wr & wdata[CTRL_ABORT];
        clr_done   = ctrl_wr & wdata[CTRL_DONE];
        clr_err    = ctrl_wr & wdata[CTRL_ERR];
        len_ext                 = '0;
        len_ext[LEN_WIDTH-1:0]  = len;
        len_merged              = byte_merge(len_ext, wdata, wstrb);
    end

    // Read mux; LEN shows the remaining count while a transfer runs
    always_comb begin
        rd_val = '0;
        case (idx)
            REG_SRC: rd_val = src;
            REG_DST: rd_val = dst;
            REG_LEN: rd_val[LEN_WIDTH-1:0] = busy ? cnt_live : len;
            default: rd_val[5:0] = {ie, dinc, sinc, err, done, busy};
        endcase
    end

    // Handshake pulse and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= acc;
            rdata <= acc ? rd_val : 32'h0;
        end
    end

    // Transfer parameters and mode bits are frozen while a transfer runs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src  <= '0;
            dst  <= '0;
            len  <= '0;
            sinc <= 1'b0;
            dinc <= 1'b0;
            ie   <= 1'b0;
        end else if (wr_acc && !busy) begin
            case (idx)
                REG_SRC: src <= byte_merge(src, wdata, wstrb);
                REG_DST: dst <= byte_merge(dst, wdata, wstrb);
                REG_LEN: len <= len_merged[LEN_WIDTH-1:0];
                default: begin
                    if (wstrb[0]) begin
                        sinc <= wdata[CTRL_SINC];
                        dinc <= wdata[CTRL_DINC];
                        ie   <= wdata[CTRL_IE];
                    end
                end
            endcase
        end
    end

    // Sticky status: a write-1 clear lands before any set in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (done & ~clr_done) | set_done | zero_start;
            err  <= (err & ~clr_err) | set_err;
        end
    end

    assign irq = ie & (done | err);

endmodule

// File: rtl/bus_dma.sv
// Single-channel memory-to-memory DMA: read a word from src, write it to dst, repeat LEN times.
// Latency: 2 cycles per bus phase minimum, 4 cycles per word against zero-wait targets.
// Backpressure: m_valid and its payload hold until m_ready; a stalled phase aborts after TIMEOUT cycles.
module bus_dma
    import bus_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    dma_state_e           state;
    logic [31:0]          src_w;
    logic [31:0]          dst_w;
    logic [LEN_WIDTH-1:0] cnt;
    logic [31:0]          buffer;
    logic [TW-1:0]        wait_cnt;
    logic                 abort_pend;

    logic [31:0]          src;
    logic [31:0]          dst;
    logic [LEN_WIDTH-1:0] len;
    logic                 sinc;
    logic                 dinc;
    logic                 go;
    logic                 abort_req;
    logic                 busy;
    logic                 hs;
    logic                 tmo;
    logic                 abort_now;
    logic                 last_word;
    logic                 set_done;
    logic                 set_err;

    bus_dma_regs #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .ready     (ready),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .cnt_live  (cnt),
        .set_done  (set_done),
        .set_err   (set_err),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .sinc      (sinc),
        .dinc      (dinc),
        .go        (go),
        .abort_req (abort_req),
        .irq       (irq)
    );

    // Phase outcomes; an abort never cuts a pending request, it waits for the handshake
    always_comb begin
        busy      = (state != ST_IDLE);
        hs        = m_valid & m_ready;
        tmo       = m_valid & ~m_ready & (wait_cnt == TW'(TIMEOUT - 1));
        abort_now = abort_pend | abort_req;
        last_word = (state == ST_WR) & (cnt == LEN_WIDTH'(1));
        set_err   = busy & tmo;
        set_done  = busy & ((hs & (abort_now | last_word)) | (~m_valid & abort_now));
    end

    // Sequencer: each phase raises m_valid one cycle after entry, drops it the cycle after m_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            src_w      <= '0;
            dst_w      <= '0;
            cnt        <= '0;
            buffer     <= '0;
            wait_cnt   <= '0;
            abort_pend <= 1'b0;
            m_valid    <= 1'b0;
            m_wstrb    <= 4'h0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            abort_pend <= abort_now;
            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    if (go) begin
                        src_w <= src;
                        dst_w <= dst;
                        cnt   <= len;
                        state <= ST_RD;
                    end
                end
                ST_RD, ST_WR: begin
                    if (!m_valid) begin
                        if (abort_now) begin
                            abort_pend <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            m_valid  <= 1'b1;
                            wait_cnt <= '0;
                            if (state == ST_RD) begin
                                m_addr  <= {src_w[31:2], 2'b00};
                                m_wstrb <= 4'h0;
                            end else begin
                                m_addr  <= {dst_w[31:2], 2'b00};
                                m_wstrb <= 4'hF;
                                m_wdata <= buffer;
                            end
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        if (abort_now) begin
                            // read data under abort is dropped, no write follows
                            abort_pend <= 1'b0;
                            state      <= ST_IDLE;
                        end else if (state == ST_RD) begin
                            buffer <= m_rdata;
                            state  <= ST_WR;
                        end else begin
                            cnt <= cnt - LEN_WIDTH'(1);
                            if (sinc) src_w <= src_w + 32'd4;
                            if (dinc) dst_w <= dst_w + 32'd4;
                            state <= last_word ? ST_IDLE : ST_RD;
                        end
                    end else if (tmo) begin
                        m_valid    <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
